// File: rtl/mesh_term_src.sv
// Mesh terminal source queue: stamps host packets with route header, FWFT FIFO toward the router.
// Head visible the cycle after a push into an empty queue; full pushes drop (counted) unless a pop coincides. Optional MESH_TERM_DEST_CHK_EN.
module mesh_term_src #(
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 4,
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int TERM_ROW   = 0,
    parameter int TERM_COL   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [3:0]                    dest_row_i,
    input  logic [3:0]                    dest_col_i,
    input  logic                          mode_i,
    input  logic [PAKG_SIZE-18:0]         payload_i,
    output logic                          full_o,
    output logic                          pndng_o,
    output logic [PAKG_SIZE-1:0]          data_out_o,
    input  logic                          popin_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic [15:0]                   drop_cnt_o,
    output logic                          overflow_o
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]      SELF_ADDR = {4'(TERM_ROW), 4'(TERM_COL)};
    localparam logic [3:0]      ROW_MAX   = 4'(ROWS);
    localparam logic [3:0]      COL_MAX   = 4'(COLUMNS);
    localparam logic [3:0]      ROW_LAST  = 4'(ROWS + 1);
    localparam logic [3:0]      COL_LAST  = 4'(COLUMNS + 1);
`ifdef MESH_TERM_DEST_CHK_EN
    localparam logic            DEST_CHK  = 1'b1;
`else
    localparam logic            DEST_CHK  = 1'b0;
`endif

    logic [PAKG_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic                 overflow_q, overflow_d;

    logic                 full, pop_vld, dest_ok, dest_rej, full_drop, push_acc;
    logic                 row_edge, col_edge, row_in, col_in;
    logic [PAKG_SIZE-1:0] pkt;

    // Terminals sit on the mesh perimeter, excluding the corners.
    always_comb begin
        row_edge = (dest_row_i == 4'd0) || (dest_row_i == ROW_LAST);
        col_edge = (dest_col_i == 4'd0) || (dest_col_i == COL_LAST);
        row_in   = (dest_row_i >= 4'd1) && (dest_row_i <= ROW_MAX);
        col_in   = (dest_col_i >= 4'd1) && (dest_col_i <= COL_MAX);
        dest_ok  = ((row_edge && col_in) || (col_edge && row_in)) &&
                   ({dest_row_i, dest_col_i} != SELF_ADDR);
    end

    always_comb begin
        full      = (count_q == DEPTH_C);
        pop_vld   = popin_i && (count_q != '0);
        dest_rej  = DEST_CHK && push_i && !dest_ok;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        full_drop = push_i && !dest_rej && full && !pop_vld;
        push_acc  = push_i && !dest_rej && !full_drop;
        pkt       = {SELF_ADDR, dest_row_i, dest_col_i, mode_i, payload_i};

        wr_ptr_d  = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_vld  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push_acc && !pop_vld) begin
            count_d = count_q + 1'b1;
        end else if (!push_acc && pop_vld) begin
            count_d = count_q - 1'b1;
        end

        drop_cnt_d = drop_cnt_q;
        if ((dest_rej || full_drop) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        overflow_d = overflow_q | full_drop;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= pkt;
        end
    end

    assign full_o     = full;
    assign pndng_o    = (count_q != '0);
    assign data_out_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mesh_term_src.sv
// Bench for mesh_term_src: scoreboard queue of expected head packets, one task per scenario.
module tb_mesh_term_src;

    logic        clk_i;
    logic        rst_i;
    logic        push_i;
    logic [3:0]  dest_row_i;
    logic [3:0]  dest_col_i;
    logic        mode_i;
    logic [14:0] payload_i;
    logic        full_o;
    logic        pndng_o;
    logic [31:0] data_out_o;
    logic        popin_i;
    logic [4:0]  count_o;
    logic [15:0] drop_cnt_o;
    logic        overflow_o;

    int          checks;
    int          fails;
    logic [31:0] sb[$];
    logic [31:0] exp_pkt;
    logic [15:0] exp_drop;

    mesh_term_src dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_i),
        .dest_row_i (dest_row_i),
        .dest_col_i (dest_col_i),
        .mode_i     (mode_i),
        .payload_i  (payload_i),
        .full_o     (full_o),
        .pndng_o    (pndng_o),
        .data_out_o (data_out_o),
        .popin_i    (popin_i),
        .count_o    (count_o),
        .drop_cnt_o (drop_cnt_o),
        .overflow_o (overflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] mk(input logic [3:0] dr, input logic [3:0] dc,
                                       input logic m, input logic [14:0] pl);
        return {4'd0, 4'd1, dr, dc, m, pl};
    endfunction

    task automatic drive(input logic p, input logic [3:0] dr, input logic [3:0] dc,
                         input logic m, input logic [14:0] pl, input logic pop);
        push_i     = p;
        dest_row_i = dr;
        dest_col_i = dc;
        mode_i     = m;
        payload_i  = pl;
        popin_i    = pop;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        checks += 6;
        if (count_o !== 5'd0)      begin fails++; $display("FAIL reset_count got %0d want 0", count_o); end
        if (pndng_o !== 1'b0)      begin fails++; $display("FAIL reset_pndng got %b want 0", pndng_o); end
        if (full_o !== 1'b0)       begin fails++; $display("FAIL reset_full got %b want 0", full_o); end
        if (data_out_o !== 32'h0)  begin fails++; $display("FAIL reset_data got %h want 0", data_out_o); end
        if (drop_cnt_o !== 16'h0)  begin fails++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
        if (overflow_o !== 1'b0)   begin fails++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        exp_drop = 16'd0;
    endtask

    task automatic test_single;
        drive(1, 4'd5, 4'd2, 1'b0, 15'h1234, 0);
        sb.push_back(mk(4'd5, 4'd2, 1'b0, 15'h1234));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks += 3;
        if (pndng_o !== 1'b1)         begin fails++; $display("FAIL single_pndng got %b want 1", pndng_o); end
        if (data_out_o !== 32'h01521234) begin fails++; $display("FAIL single_data got %h want 01521234", data_out_o); end
        if (count_o !== 5'd1)         begin fails++; $display("FAIL single_count got %0d want 1", count_o); end
        popin_i = 1'b1;
        exp_pkt = sb.pop_front();
        checks++;
        if (data_out_o !== exp_pkt)   begin fails++; $display("FAIL single_pop got %h want %h", data_out_o, exp_pkt); end
        tick();
        popin_i = 1'b0;
        checks += 2;
        if (count_o !== 5'd0)         begin fails++; $display("FAIL single_drain got %0d want 0", count_o); end
        if (pndng_o !== 1'b0)         begin fails++; $display("FAIL single_pndng0 got %b want 0", pndng_o); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'd5, 4'(i % 4 + 1), i[0], 15'(16'h100 + i), 0);
            sb.push_back(mk(4'd5, 4'(i % 4 + 1), i[0], 15'(16'h100 + i)));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checks += 3;
        if (full_o !== 1'b1)      begin fails++; $display("FAIL fill_full got %b want 1", full_o); end
        if (count_o !== 5'd16)    begin fails++; $display("FAIL fill_count got %0d want 16", count_o); end
        if (overflow_o !== 1'b0)  begin fails++; $display("FAIL fill_ovf got %b want 0", overflow_o); end
        drive(1, 4'd0, 4'd3, 1'b1, 15'h7FFF, 0);
        exp_drop++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks += 4;
        if (overflow_o !== 1'b1)      begin fails++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
        if (drop_cnt_o !== exp_drop)  begin fails++; $display("FAIL ovf_drop got %0d want %0d", drop_cnt_o, exp_drop); end
        if (count_o !== 5'd16)        begin fails++; $display("FAIL ovf_count got %0d want 16", count_o); end
        if (data_out_o !== sb[0])     begin fails++; $display("FAIL ovf_head got %h want %h", data_out_o, sb[0]); end
    endtask

    task automatic test_full_push_pop;
        drive(1, 4'd3, 4'd5, 1'b1, 15'h2AAA, 1);
        exp_pkt = sb.pop_front();
        checks++;
        if (data_out_o !== exp_pkt) begin fails++; $display("FAIL fpp_head got %h want %h", data_out_o, exp_pkt); end
        sb.push_back(mk(4'd3, 4'd5, 1'b1, 15'h2AAA));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks += 4;
        if (count_o !== 5'd16)       begin fails++; $display("FAIL fpp_count got %0d want 16", count_o); end
        if (full_o !== 1'b1)         begin fails++; $display("FAIL fpp_full got %b want 1", full_o); end
        if (drop_cnt_o !== exp_drop) begin fails++; $display("FAIL fpp_drop got %0d want %0d", drop_cnt_o, exp_drop); end
        if (data_out_o !== sb[0])    begin fails++; $display("FAIL fpp_adv got %h want %h", data_out_o, sb[0]); end
        for (int i = 0; i < 16; i++) begin
            popin_i = 1'b1;
            exp_pkt = sb.pop_front();
            checks++;
            if (data_out_o !== exp_pkt) begin fails++; $display("FAIL fpp_drain%0d got %h want %h", i, data_out_o, exp_pkt); end
            tick();
        end
        popin_i = 1'b0;
        checks++;
        if (count_o !== 5'd0) begin fails++; $display("FAIL fpp_empty got %0d want 0", count_o); end
    endtask

    task automatic test_random_order;
        int pushes = 0;
        int pops = 0;
        int cyc = 0;
        logic       do_push, do_pop;
        logic [3:0] dr;
        logic [14:0] pl;
        while (pops < 40 && cyc < 600) begin
            do_pop  = (sb.size() > 0) && ($urandom_range(0, 2) != 0);
            do_push = (pushes < 40) && ($urandom_range(0, 1) == 1) &&
                      ((sb.size() < 16) || do_pop);
            dr = 4'($urandom_range(1, 4));
            pl = 15'($urandom);
            drive(do_push, dr, 4'd0, pl[0], pl, do_pop);
            if (do_pop) begin
                exp_pkt = sb.pop_front();
                pops++;
                checks++;
                if (data_out_o !== exp_pkt) begin fails++; $display("FAIL rnd_order pop%0d got %h want %h", pops, data_out_o, exp_pkt); end
            end
            if (do_push) begin
                sb.push_back(mk(dr, 4'd0, pl[0], pl));
                pushes++;
            end
            tick();
            cyc++;
            checks++;
            if (count_o !== 5'(sb.size())) begin fails++; $display("FAIL rnd_count cyc%0d got %0d want %0d", cyc, count_o, sb.size()); end
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (pops != 40) begin fails++; $display("FAIL rnd_budget got %0d pops want 40", pops); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'(i + 1), 4'd5, 1'b0, 15'(i), 0);
            sb.push_back(mk(4'(i + 1), 4'd5, 1'b0, 15'(i)));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (count_o !== 5'd5) begin fails++; $display("FAIL ar_pre got %0d want 5", count_o); end
        #3;
        rst_i = 1'b0;
        #1;
        checks += 6;
        if (count_o !== 5'd0)      begin fails++; $display("FAIL ar_count got %0d want 0", count_o); end
        if (pndng_o !== 1'b0)      begin fails++; $display("FAIL ar_pndng got %b want 0", pndng_o); end
        if (full_o !== 1'b0)       begin fails++; $display("FAIL ar_full got %b want 0", full_o); end
        if (data_out_o !== 32'h0)  begin fails++; $display("FAIL ar_data got %h want 0", data_out_o); end
        if (drop_cnt_o !== 16'h0)  begin fails++; $display("FAIL ar_drop got %0d want 0", drop_cnt_o); end
        if (overflow_o !== 1'b0)   begin fails++; $display("FAIL ar_ovf got %b want 0", overflow_o); end
        sb.delete();
        exp_drop = 16'd0;
        #2;
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks += 2;
        if (count_o !== 5'd0)  begin fails++; $display("FAIL ar_pop_ign got %0d want 0", count_o); end
        if (pndng_o !== 1'b0)  begin fails++; $display("FAIL ar_pndng2 got %b want 0", pndng_o); end
        drive(1, 4'd0, 4'd4, 1'b1, 15'h0ABC, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (data_out_o !== 32'h0104_8ABC) begin fails++; $display("FAIL ar_fresh got %h want 01048abc", data_out_o); end
        popin_i = 1'b1;
        tick();
        popin_i = 1'b0;
    endtask

    task automatic test_dest_check;
        drive(1, 4'd2, 4'd2, 1'b0, 15'h0011, 0);
        tick();
        drive(1, 4'd0, 4'd1, 1'b0, 15'h0022, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
`ifdef MESH_TERM_DEST_CHK_EN
        checks += 3;
        if (count_o !== 5'd0)     begin fails++; $display("FAIL dest_count got %0d want 0", count_o); end
        if (drop_cnt_o !== 16'd2) begin fails++; $display("FAIL dest_drop got %0d want 2", drop_cnt_o); end
        if (overflow_o !== 1'b0)  begin fails++; $display("FAIL dest_ovf got %b want 0", overflow_o); end
`else
        sb.push_back(32'h0122_0011);
        sb.push_back(32'h0101_0022);
        checks += 3;
        if (count_o !== 5'd2)     begin fails++; $display("FAIL dest_count got %0d want 2", count_o); end
        if (drop_cnt_o !== 16'd0) begin fails++; $display("FAIL dest_drop got %0d want 0", drop_cnt_o); end
        if (overflow_o !== 1'b0)  begin fails++; $display("FAIL dest_ovf got %b want 0", overflow_o); end
        for (int i = 0; i < 2; i++) begin
            popin_i = 1'b1;
            exp_pkt = sb.pop_front();
            checks++;
            if (data_out_o !== exp_pkt) begin fails++; $display("FAIL dest_pkt%0d got %h want %h", i, data_out_o, exp_pkt); end
            tick();
        end
        popin_i = 1'b0;
`endif
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        exp_drop = 16'd0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_random_order();
        test_async_reset();
        test_dest_check();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mesh_term_src.md
MESH_TERM_SRC -- requirements
Module: mesh_term_src

Interface
- REQ-001 SHALL have parameter ROWS, default 4, meaning mesh row count.
- REQ-002 SHALL have parameter COLUMNS, default 4, meaning mesh column count.
- REQ-003 SHALL have parameter PAKG_SIZE, default 32, meaning packet width in bits (minimum 24).
- REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning queue depth; power of two, at least 2.
- REQ-005 SHALL have parameter TERM_ROW, default 0, and parameter TERM_COL, default 1, meaning the 4-bit address of this terminal.
- REQ-006 SHALL use one clock; reset is asynchronous and active-low.
- REQ-007 SHALL have port clk_i, input, 1 bit: the single clock; all logic on the rising edge.
- REQ-008 SHALL have port rst_i, input, 1 bit: asynchronous active-low reset.
- REQ-009 SHALL have port push_i, input, 1 bit: the local host offers a packet this cycle.
- REQ-010 SHALL have ports dest_row_i and dest_col_i, input, 4 bits each: destination terminal address.
- REQ-011 SHALL have port mode_i, input, 1 bit: routing mode bit, passed through unchanged.
- REQ-012 SHALL have port payload_i, input, PAKG_SIZE-17 bits: packet payload.
- REQ-013 SHALL have port full_o, output, 1 bit: queue holds FIFO_DEPTH entries.
- REQ-014 SHALL have port pndng_o, output, 1 bit: a packet is pending for the router; drives the router's pndng_i_in.
- REQ-015 SHALL have port data_out_o, output, PAKG_SIZE bits: the head packet; drives the router's data_out_i_in.
- REQ-016 SHALL have port popin_i, input, 1 bit: the router consumes the head packet; driven by the router's popin.
- REQ-017 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
- REQ-018 SHALL have port drop_cnt_o, output, 16 bits: count of rejected pushes.
- REQ-019 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a push is lost because the queue is full.

Function
- REQ-020 SHALL assemble each packet as follows, from most significant bits down:
  - bits [PAKG_SIZE-1:PAKG_SIZE-8] = {TERM_ROW[3:0], TERM_COL[3:0]}
  - then dest_row_i (4 bits), then dest_col_i (4 bits), then mode_i (1 bit)
  - then payload_i in the remaining low bits.
- REQ-021 SHALL accept a push only when push_i=1 and the push is neither full-rejected nor destination-rejected; an accepted packet is written at the rising edge.
- REQ-022 SHALL operate first-word-fall-through: pndng_o=(count_o!=0), and data_out_o always shows the head entry.
- REQ-023 SHALL give a packet accepted on edge N pndng_o=1 and that packet on data_out_o after edge N, when the queue was empty.
- REQ-024 SHALL treat popin_i=1 with pndng_o=1 as removing the head at the edge; popin_i is ignored when pndng_o=0.
- REQ-025 SHALL handle simultaneous accepted push and valid pop by performing both, leaving count_o unchanged; this applies when full (the push is accepted) and at count 1.
- REQ-026 SHALL, on push_i=1 with a full queue and no pop in the same cycle, discard the packet, set overflow_o, and increment drop_cnt_o.
- REQ-027 SHALL let read and write pointers wrap modulo FIFO_DEPTH with no data corruption.
- REQ-028 SHALL saturate drop_cnt_o at 16'hFFFF.
- REQ-029 SHALL set full_o=(count_o==FIFO_DEPTH).

Reset
- REQ-030 SHALL, while rst_i=0, immediately force count_o=0, pndng_o=0, full_o=0, data_out_o=0, drop_cnt_o=0, overflow_o=0, and pointers to 0.
- REQ-031 SHALL discard queued contents on reset asserted mid-operation; the first edge after release behaves as from an empty queue.

Configuration
- REQ-032 SHALL provide macro MESH_TERM_DEST_CHK_EN; when defined, a push SHALL be rejected unless the destination is a valid terminal address other than self.
- REQ-033 SHALL, with MESH_TERM_DEST_CHK_EN defined, treat a destination as valid when either:
  - row is 0 or ROWS+1 and col is in 1..COLUMNS, or
  - col is 0 or COLUMNS+1 and row is in 1..ROWS.
- REQ-034 SHALL, with MESH_TERM_DEST_CHK_EN defined, increment drop_cnt_o for a destination-rejected push but leave overflow_o unchanged.
- REQ-035 SHALL, without MESH_TERM_DEST_CHK_EN, accept all destinations, with drop_cnt_o counting only full-queue drops.

Verification (ROWS=COLUMNS=4, PAKG_SIZE=32, FIFO_DEPTH=16, TERM 0/1)
- REQ-036 SHALL cover this scenario: push dest (5,2), mode 0, payload 15'h1234 -> next cycle pndng_o=1, data_out_o=32'h01520000|15'h1234, count_o=1.
- REQ-037 SHALL cover this scenario: 16 pushes with no pop -> full_o=1; a 17th push -> overflow_o=1, drop_cnt_o=1, count_o stays 16.
- REQ-038 SHALL cover this scenario: full queue with push and popin_i together -> count_o=16, head advances, new packet is at the tail, drop_cnt_o unchanged.
- REQ-039 SHALL cover this scenario: 40 push/pop pairs with random occupancy -> output order equals input order across pointer wrap.
- REQ-040 SHALL cover this scenario, with MESH_TERM_DEST_CHK_EN defined: push dest (2,2), then push dest (0,1) -> both rejected, drop_cnt_o=2, overflow_o=0; without the macro, both are accepted.
- REQ-041 SHALL cover this scenario: rst_i pulled low asynchronously between edges with count 5 -> all outputs 0 before the next edge; after release, popin_i=1 has no effect.
